// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
// Default geometry lives here so the interface and modules agree on widths.
package matmul_pkg;

   localparam int DEF_BITS = 8;
   localparam int DEF_N    = 8;
   localparam int IDX_W    = $clog2(DEF_N);
   localparam int ROW_W    = DEF_N * DEF_BITS;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FETCH,
      MULT,
      WRITE,
      CHECK,
      DONE
   } seq_state_t;

   // Each lane keeps only the low bits of its product; no saturation.
   function automatic logic [ROW_W-1:0] row_mult(input logic [DEF_BITS-1:0] elem,
                                                 input logic [ROW_W-1:0]    row);
      logic [ROW_W-1:0] res;
      res = '0;
      for (int j = 0; j < DEF_N; j++) begin
         res[j*DEF_BITS +: DEF_BITS] = elem * row[j*DEF_BITS +: DEF_BITS];
      end
      return res;
   endfunction

endpackage

// File: rtl/matmul_seq_if.sv
// Bundle of the sequencer's control, source-memory and accumulator signals.
// The sequencer uses the slave view; the surrounding system uses master.
interface matmul_seq_if #(
   parameter int BITS = matmul_pkg::DEF_BITS,
   parameter int N    = matmul_pkg::DEF_N
);

   localparam int AW = $clog2(N);

   logic              start;
   logic              busy;
   logic              done;
   logic              err;
   logic [2*AW-1:0]   a_addr;
   logic [AW-1:0]     b_addr;
   logic [BITS-1:0]   a_elem;
   logic [N*BITS-1:0] b_row;
   logic              out_rst_n;
   logic [9:0]        out_addr;
   logic [N*BITS-1:0] out_row;
   logic              out_wr_en;
   logic              out_stored;

   modport slave (
      input  start, a_elem, b_row, out_stored,
      output busy, done, err, a_addr, b_addr, out_rst_n, out_addr, out_row, out_wr_en
   );

   modport master (
      output start, a_elem, b_row, out_stored,
      input  busy, done, err, a_addr, b_addr, out_rst_n, out_addr, out_row, out_wr_en
   );

endinterface

// File: rtl/matmul_seq_row_mult.sv
// Combinational N-lane scalar-times-row multiplier, each lane truncated to BITS.
module matmul_row_mult
   import matmul_pkg::*;
#(
   parameter int BITS = DEF_BITS,
   parameter int N    = DEF_N
) (
   input  logic [BITS-1:0]   elem,
   input  logic [N*BITS-1:0] row,
   output logic [N*BITS-1:0] prod
);

   // The default geometry reuses the shared helper; other sizes get explicit lanes.
   if (BITS == DEF_BITS && N == DEF_N) begin : g_default
      assign prod = row_mult(elem, row);
   end else begin : g_generic
      for (genvar j = 0; j < N; j++) begin : g_lane
         assign prod[j*BITS +: BITS] = elem * row[j*BITS +: BITS];
      end
   end

endmodule

// File: rtl/matmul_seq.sv
// Sequencer for one C = A x B pass: walks (i,k) with k innermost, fetches A[i][k]
// and row B[k], and issues one accumulate write of the partial-product row per pair.
module matmul_seq
   import matmul_pkg::*;
#(
   parameter int BITS     = DEF_BITS,
   parameter int N        = DEF_N,
   parameter int OUT_BASE = 0
) (
   input  logic         clk,
   input  logic         rst,
   matmul_seq_if.slave  bus
);

   localparam int            AW   = $clog2(N);
   localparam int            RW   = N * BITS;
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   seq_state_t    state;
   logic [AW-1:0] i_idx;
   logic [AW-1:0] k_idx;
   logic [AW-1:0] i_next;
   logic [AW-1:0] k_next;
   logic          stored_q;
   logic [RW-1:0] prod_row;

   matmul_row_mult #(
      .BITS (BITS),
      .N    (N)
   ) u_row_mult (
      .elem (bus.a_elem),
      .row  (bus.b_row),
      .prod (prod_row)
   );

   // k wraps naturally in AW bits because N is a power of two.
   assign k_next = k_idx + 1'b1;
   assign i_next = (k_idx == LAST) ? i_idx + 1'b1 : i_idx;

   // Addresses are presented on entry to FETCH so the source data lands in MULT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         i_idx         <= '0;
         k_idx         <= '0;
         stored_q      <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.out_wr_en <= 1'b0;
         bus.out_rst_n <= 1'b1;
         bus.out_row   <= '0;
         bus.out_addr  <= 10'(OUT_BASE);
         bus.a_addr    <= '0;
         bus.b_addr    <= '0;
      end else begin
         bus.done      <= 1'b0;
         bus.out_wr_en <= 1'b0;
         bus.out_rst_n <= 1'b1;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state         <= CLEAR;
                  bus.err       <= 1'b0;
                  bus.busy      <= 1'b1;
                  bus.out_rst_n <= 1'b0;
                  i_idx         <= '0;
                  k_idx         <= '0;
               end
            end
            CLEAR: begin
               state      <= FETCH;
               bus.a_addr <= {i_idx, k_idx};
               bus.b_addr <= k_idx;
            end
            FETCH: begin
               state <= MULT;
            end
            MULT: begin
               state         <= WRITE;
               bus.out_row   <= prod_row;
               bus.out_addr  <= 10'(OUT_BASE + int'(i_idx) * N);
               bus.out_wr_en <= 1'b1;
            end
            WRITE: begin
               state    <= CHECK;
               stored_q <= bus.out_stored;
            end
            CHECK: begin
               if (!stored_q) begin
                  state    <= DONE;
                  bus.err  <= 1'b1;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end else if (i_idx == LAST && k_idx == LAST) begin
                  state    <= DONE;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end else begin
                  state      <= FETCH;
                  k_idx      <= k_next;
                  i_idx      <= i_next;
                  bus.a_addr <= {i_next, k_next};
                  bus.b_addr <= k_next;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
